pc_return_stack: RTL and testbench

- Return-address stack on the consumer side of the program counter.
- Samples the PC output on subroutine call and pushes PC+1 as the return address.
- Drives the PC's parallel-load data and load strobe: the call target on call, the popped return address on return.
- Sits between the control/decode logic and the N-bit program counter, closing the PC load path.

---
 rtl/pc_return_stack_pkg.sv | 12 +
 rtl/pc_return_stack_if.sv | 34 +++
 rtl/pc_return_stack_lifo_ram.sv | 24 ++
 rtl/pc_return_stack.sv | 90 +++++++++
 tb/tb_pc_return_stack.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/pc_return_stack_pkg.sv
// Shared defaults and helpers for the PC return-address stack.
package pc_return_stack_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_return_stack_if.sv
// Control/decode-side bus of the return stack: requests in, PC load path and status out.
interface pc_return_stack_if
    import pc_return_stack_pkg::*;
#(
    parameter int n     = ADDR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = cnt_w(DEPTH);

    logic          call;
    logic          ret;
    logic [n-1:0]  pc_in;
    logic [n-1:0]  target;
    logic [n-1:0]  pc_ld_data;
    logic          pc_ld;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic          conflict;

    // Control logic side: issues call/ret, watches the load path and status.
    modport master (
        output call, ret, pc_in, target,
        input  pc_ld_data, pc_ld, count, empty, full, overflow, underflow, conflict
    );

    // Return stack side.
    modport slave (
        input  call, ret, pc_in, target,
        output pc_ld_data, pc_ld, count, empty, full, overflow, underflow, conflict
    );
endinterface

// File: rtl/pc_return_stack_lifo_ram.sv
// DEPTH x n register file: one synchronous write port, one combinational read port.
module lifo_ram
    import pc_return_stack_pkg::*;
#(
    parameter int n     = ADDR_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [n-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [n-1:0]  rdata
);
    logic [n-1:0] mem [DEPTH];

    // Storage is not reset; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pc_return_stack.sv
// Return-address stack closing the PC load path: pushes PC+1 on call and
// loads the target, pops and loads the return address on ret.
module pc_return_stack
    import pc_return_stack_pkg::*;
#(
    parameter int n     = ADDR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic clk,
    input logic rst,
    pc_return_stack_if.slave bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] ptr;       // index of the current top entry
    logic [CW-1:0] count;
    logic [n-1:0]  ld_data;
    logic          ld;
    logic          overflow;
    logic          underflow;
    logic          conflict;
    logic          empty;
    logic          full;
    logic          push;
    logic [PW-1:0] push_addr;
    logic [n-1:0]  ret_addr;
    logic [n-1:0]  top_data;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Call always wins over ret, so any call is a push. Push pre-increments
    // the pointer; when full this lands on the oldest entry and overwrites it.
    assign push      = bus.call && !rst;
    assign push_addr = ptr + PW'(1);
    assign ret_addr  = bus.pc_in + n'(1);

    lifo_ram #(.n(n), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (push_addr),
        .wdata (ret_addr),
        .raddr (ptr),
        .rdata (top_data)
    );

    // Pointer, count, sticky flags and registered PC load outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            ld        <= 1'b0;
            ld_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            ld       <= 1'b0;
            conflict <= bus.call && bus.ret;
            if (bus.call) begin
                ptr     <= push_addr;
                ld      <= 1'b1;
                ld_data <= bus.target;
                if (full) overflow <= 1'b1;
                else      count    <= count + CW'(1);
            end else if (bus.ret) begin
                if (empty) begin
                    // Nothing to pop: no load, data holds its previous value.
                    underflow <= 1'b1;
                end else begin
                    ld      <= 1'b1;
                    ld_data <= top_data;
                    ptr     <= ptr - PW'(1);
                    count   <= count - CW'(1);
                end
            end
        end
    end

    assign bus.pc_ld      = ld;
    assign bus.pc_ld_data = ld_data;
    assign bus.count      = count;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;
    assign bus.conflict   = conflict;
endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench: the driver pushes expected post-edge outputs from a
// queue-based stack model; a negedge monitor pops and compares.
module tb_pc_return_stack;
    localparam int N  = 8;
    localparam int D  = 4;

    typedef struct {
        logic       ld;
        logic [7:0] data;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic       cfl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_return_stack_if #(.n(N), .DEPTH(D)) bus ();

    pc_return_stack #(.n(N), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    // Reference model state: a plain list of return addresses, newest last.
    logic [7:0] m_stk[$];
    logic [7:0] m_data;
    logic       m_ovf, m_unf;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every negedge after a driven edge, compare the DUT outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_ld",      int'(bus.pc_ld),      int'(e.ld));
            chk("pc_ld_data", int'(bus.pc_ld_data), int'(e.data));
            chk("count",      int'(bus.count),      e.cnt);
            chk("empty",      int'(bus.empty),      int'(e.cnt == 0));
            chk("full",       int'(bus.full),       int'(e.cnt == D));
            chk("overflow",   int'(bus.overflow),   int'(e.ovf));
            chk("underflow",  int'(bus.underflow),  int'(e.unf));
            chk("conflict",   int'(bus.conflict),   int'(e.cfl));
        end
    end

    // Apply one cycle of stimulus, predict the result, and advance past the edge.
    task automatic step(input logic c, input logic r, input logic rs,
                        input logic [7:0] pc, input logic [7:0] tgt);
        exp_t e;
        logic [7:0] ra;
        rst = rs; bus.call = c; bus.ret = r; bus.pc_in = pc; bus.target = tgt;
        e.ld = 1'b0;
        e.cfl = 1'b0;
        if (rs) begin
            m_stk.delete();
            m_data = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (c) begin
            ra = pc + 8'd1;
            m_stk.push_back(ra);
            if (m_stk.size() > D) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            e.ld = 1'b1;
            m_data = tgt;
            e.cfl = r;
        end else if (r) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else begin
                m_data = m_stk.pop_back();
                e.ld = 1'b1;
            end
        end
        e.data = m_data; e.cnt = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt);
        step(1'b1, 1'b0, 1'b0, pc, tgt);
    endtask

    task automatic do_ret();
        step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        m_data = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        // 1. reset for two cycles
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        // 2. call then return
        do_call(8'h31, 8'h80);
        do_ret();
        // 3. address wrap
        do_call(8'hFF, 8'h22);
        do_ret();
        // 4. overflow then drain into underflow
        for (int i = 0; i < 5; i++) do_call(8'(8'h10 + i), 8'(8'hA0 + i));
        for (int i = 0; i < 5; i++) do_ret();
        // 5. conflict
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        do_call(8'h40, 8'h70);
        step(1'b1, 1'b1, 1'b0, 8'h50, 8'h90);
        do_ret();
        do_ret();
        // 6. reset coincident with call mid-operation, then ret on empty
        do_call(8'h60, 8'h61);
        do_call(8'h62, 8'h63);
        step(1'b1, 1'b0, 1'b1, 8'h64, 8'h65);
        do_ret();
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 59) == 0), 8'($urandom), 8'($urandom));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
